// File: rtl/mips_reg_file.sv
// mips_reg_file -- architectural register file for the single-cycle MIPS core.
//
// 2^ADDR_W x DATA_W registers. There are two combinational read ports (rs, rt)
// and one synchronous write port. After every reset an init sequencer clears
// one entry per cycle. `ready` rises once the last entry has been cleared.
//
// Ports:
//   clk                 single clock, rising edge
//   rst_n               synchronous active-low reset
//   rs_addr, rt_addr    read port addresses
//   rd_data_a/b         combinational read data (0 while !ready or addr==0)
//   wr_en, wr_addr,     write port (RegWrite, write-register mux output,
//   wr_data             ALU result / load data); ignored until ready
//   ready               init clear complete, file accepts writes
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a same-cycle write to a port's address is forwarded to that
//                port (write-before-read)
//   undefined -> reads return the array value; no wr_* -> rd_data_* path
module mips_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DATA_W-1:0] regs [DEPTH];

  // Init sequencer. Reset restarts the clear from any state. The edge that
  // clears the last entry also raises ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
    end else if (state == INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == '1) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end
  end

  // The array has no reset of its own. It is cleared by the sequencer. An edge
  // with rst_n low leaves the contents unchanged.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT)
        regs[init_ptr] <= '0;
      else if (wr_en && wr_addr != '0)
        regs[wr_addr] <= wr_data;
    end
  end

  // Read ports. Address 0 and the not-ready state both force 0. Under bypass,
  // a nonzero port address already implies wr_addr != 0 on a match.
  always_comb begin
    rd_data_a = '0;
    if (ready && rs_addr != '0) begin
      rd_data_a = regs[rs_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == rs_addr) rd_data_a = wr_data;
`endif
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (ready && rt_addr != '0) begin
      rd_data_b = regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == rt_addr) rd_data_b = wr_data;
`endif
    end
  end

endmodule

// File: doc/mips_reg_file.md
# mips_reg_file

Architectural register file for the single-cycle MIPS processor: 2^ADDR_W × DATA_W general-purpose registers with two combinational read ports (rs, rt) and one synchronous write port. It sits directly downstream of the 5-bit write-register select mux, which drives `wr_addr`, and feeds the ALU operand path and the store-data path. After every reset, an internal init sequencer clears the array one entry per cycle, and the block signals `ready` when the clear is complete.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: register address width; depth is 2^ADDR_W.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `rs_addr`  in  ADDR_W  read port A address.
- `rt_addr`  in  ADDR_W  read port B address.
- `rd_data_a`  out  DATA_W  read port A data (combinational).
- `rd_data_b`  out  DATA_W  read port B data (combinational).
- `wr_en`  in  1  write enable (RegWrite).
- `wr_addr`  in  ADDR_W  write address, from the write-register select mux.
- `wr_data`  in  DATA_W  write data (ALU result or memory load data).
- `ready`  out  1  high once the init clear is complete and the file accepts writes.

## Operation
- FSM has two states, INIT and RUN, held in a registered state bit and an ADDR_W-bit `init_ptr`.
- **Reset.** A rising edge with `rst_n`=0 sets state to INIT, `init_ptr` to 0 and `ready` to 0. Reset asserted during RUN aborts operation identically. Array contents are not touched by reset itself.
- **INIT.** On each rising edge with `rst_n`=1:
  - reg[`init_ptr`] is set to 0, then `init_ptr` increments.
  - On the edge that clears entry 2^ADDR_W−1, state moves to RUN and `ready` goes to 1.
  - `wr_en` is ignored throughout INIT.
- **RUN, write.** On a rising edge with `wr_en`=1 and `wr_addr`≠0, reg[`wr_addr`] is set to `wr_data`. A write to address 0 is discarded.
- **Read.** For each port independently:
  - data = 0 if `ready`=0 or the port address is 0;
  - otherwise, bypass per Configuration;
  - otherwise, the array entry.
  - Reads are purely combinational from addresses and state: no latency, no registered outputs.
- **Same-address reads.** Both ports may read the same address, including `wr_addr`, in the same cycle without conflict.
- **Register 0.** Reads as 0 at all times, regardless of array contents.

## Timing
- Reset values: `ready`=0; `rd_data_a` and `rd_data_b` = 0 because `ready`=0.
- `ready` rises exactly 2^ADDR_W rising edges after the first edge with `rst_n`=1, which is 32 edges at the defaults.
- Write latency is one edge: data is visible on the read ports from the cycle after the write edge. It is visible in the same cycle only with bypass enabled.
- The write and both reads can occur every cycle; there are no stalls in RUN.
- Setup paths: `wr_*` to `clk`. Combinational paths: `*_addr` (and `wr_*` if bypassed) to `rd_data_*`.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** when `ready`=1, `wr_en`=1, `wr_addr`≠0 and `wr_addr` equals a port address, that port returns `wr_data` combinationally in the same cycle (write-before-read).
- **`REGFILE_BYPASS_EN` undefined:** that port returns the old array value until the write edge; there is no `wr_*`-to-`rd_data_*` path.

## Test plan
- **Reset and init:** hold `rst_n`=0 for 3 edges, then release → `ready`=0 for 31 edges and 1 on the 32nd; all 32 addresses read 0 after `ready` rises.
- **Write and read back:** write 0xDEADBEEF to r8 and 0x12345678 to r31 → next cycle `rs_addr`=8 gives 0xDEADBEEF and `rt_addr`=31 gives 0x12345678 simultaneously.
- **$zero protection:** write 0xFFFFFFFF to r0 → both ports read 0 at address 0; no other register changes.
- **Same-cycle read of the write address:** `wr_en`=1, `wr_addr`=`rs_addr`=5, r5 previously 0xA, `wr_data`=0xB.
  - With the macro: `rd_data_a`=0xB in the same cycle.
  - Without the macro: `rd_data_a`=0xA in the same cycle, then 0xB after the edge.
- **Writes during INIT:** assert `wr_en`=1 to r3 with 0x55 while `ready`=0 → r3 reads 0 after `ready`=1.
- **Mid-run reset:** load r9=0x77, then pulse `rst_n`=0 for one edge → `ready`=0 on the next edge; after 32 further edges r9 reads 0.
